// File: rtl/snn_pkg.sv
// Shared types and defaults for the SNN timestep scheduler.
package snn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCEPT,
        DRIVE,
        SAMPLE,
        ARGMAX,
        FINISH
    } sched_state_t;

    localparam int SNN_DEF_CNT_WIDTH = 8;
    localparam int SNN_DEF_NUM_STEPS = 16;

endpackage

// File: rtl/snn_spike_counter.sv
// Saturating per-neuron spike counter with synchronous clear; 1-cycle update latency.
// Holds at all-ones; the clear wins over a same-cycle increment.
module snn_spike_counter
    import snn_pkg::*;
#(
    parameter int CNT_WIDTH = SNN_DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/snn_timestep_scheduler.sv
// Clears a neuron layer, pulses NUM_STEPS accepted spike vectors into it (3 cycles/step minimum,
// waits indefinitely in ACCEPT for in_valid) and counts output spikes; SNN_SCHED_WINNER_EN adds argmax.
module snn_timestep_scheduler
    import snn_pkg::*;
#(
    parameter int NUM_INPUTS   = 4,
    parameter int NUM_NEURONS  = 4,
    parameter int NUM_STEPS    = SNN_DEF_NUM_STEPS,
    parameter int CNT_WIDTH    = SNN_DEF_CNT_WIDTH,
    parameter int CLEAR_CYCLES = 2,
    localparam int WIN_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_INPUTS-1:0]            in_spikes,
    output logic                             neuron_rst,
    output logic [NUM_INPUTS-1:0]            neuron_spike_in,
    input  logic [NUM_NEURONS-1:0]           neuron_spike_out,
    output logic [NUM_NEURONS*CNT_WIDTH-1:0] spike_count,
    output logic [WIN_W-1:0]                 winner,
    output logic                             winner_valid
);

    localparam int CLR_W  = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [CLR_W-1:0]  CLR_LAST  = CLR_W'(CLEAR_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_STEPS - 1);

    sched_state_t          state, state_nxt;
    logic [CLR_W-1:0]      clr_cnt;
    logic [STEP_W-1:0]     step_cnt;
    logic [NUM_INPUTS-1:0] spike_reg;
    logic                  cnt_clr;
    logic [CNT_WIDTH-1:0]  cnt [NUM_NEURONS];

    assign cnt_clr = (state == IDLE) && start;

    for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_cnt
        snn_spike_counter #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .clr  (cnt_clr),
            .inc  ((state == SAMPLE) && neuron_spike_out[i]),
            .count(cnt[i])
        );
        assign spike_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
    end

`ifdef SNN_SCHED_WINNER_EN
    localparam sched_state_t AFTER_STEPS = ARGMAX;
    localparam logic [WIN_W-1:0] SCAN_LAST = WIN_W'(NUM_NEURONS - 1);

    logic [WIN_W-1:0]     scan_idx, best_idx, winner_q;
    logic [CNT_WIDTH-1:0] best_cnt, scan_cnt;
    logic                 scan_gt, winner_valid_q;

    assign scan_cnt = cnt[scan_idx];
    // Strict compare against a zero seed: ties keep the lower index, all-zero leaves index 0.
    assign scan_gt  = scan_cnt > best_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_idx       <= '0;
            best_idx       <= '0;
            best_cnt       <= '0;
            winner_q       <= '0;
            winner_valid_q <= 1'b0;
        end else begin
            if (cnt_clr) begin
                winner_valid_q <= 1'b0;
            end
            if (state == SAMPLE) begin
                scan_idx <= '0;
                best_idx <= '0;
                best_cnt <= '0;
            end
            if (state == ARGMAX) begin
                scan_idx <= scan_idx + WIN_W'(1);
                if (scan_gt) begin
                    best_idx <= scan_idx;
                    best_cnt <= scan_cnt;
                end
                if (scan_idx == SCAN_LAST) begin
                    winner_q       <= scan_gt ? scan_idx : best_idx;
                    winner_valid_q <= scan_gt || (best_cnt != '0);
                end
            end
        end
    end

    assign winner       = winner_q;
    assign winner_valid = winner_valid_q;
`else
    localparam sched_state_t AFTER_STEPS = FINISH;

    assign winner       = '0;
    assign winner_valid = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (start) state_nxt = CLEAR;
            CLEAR:  if (clr_cnt == CLR_LAST) state_nxt = ACCEPT;
            ACCEPT: if (in_valid) state_nxt = DRIVE;
            DRIVE:  state_nxt = SAMPLE;
            SAMPLE: state_nxt = (step_cnt == STEP_LAST) ? AFTER_STEPS : ACCEPT;
`ifdef SNN_SCHED_WINNER_EN
            ARGMAX: if (scan_idx == SCAN_LAST) state_nxt = FINISH;
`endif
            FINISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_cnt   <= '0;
            step_cnt  <= '0;
            spike_reg <= '0;
        end else begin
            if (cnt_clr) begin
                clr_cnt  <= '0;
                step_cnt <= '0;
            end
            if (state == CLEAR) begin
                clr_cnt <= clr_cnt + CLR_W'(1);
            end
            if (state == SAMPLE) begin
                step_cnt <= step_cnt + STEP_W'(1);
            end
            if ((state == ACCEPT) && in_valid) begin
                spike_reg <= in_spikes;
            end
        end
    end

    assign busy            = (state != IDLE);
    assign done            = (state == FINISH);
    assign in_ready        = (state == ACCEPT);
    assign neuron_rst      = (state == CLEAR);
    assign neuron_spike_in = (state == DRIVE) ? spike_reg : '0;

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// Directed bench: three scheduler configurations checked every cycle against an event-timeline
// model of the presentation, plus literal expectations for each scenario.
module tb_snn_timestep_scheduler;

    localparam int NU  = 3;
    localparam int CLR = 2;
    localparam int NS_T [NU] = '{4, 6, 6};
    localparam int CW_T [NU] = '{8, 2, 8};
`ifdef SNN_SCHED_WINNER_EN
    localparam bit WEN = 1'b1;
`else
    localparam bit WEN = 1'b0;
`endif
    localparam int SCAN = WEN ? 4 : 0;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_s  [NU];
    logic       in_vld_s [NU];
    logic [3:0] in_spk   [NU];
    logic [3:0] so_s     [NU];
    logic       busy_w [NU];
    logic       done_w [NU];
    logic       rdy_w  [NU];
    logic       nrst_w [NU];
    logic       wv_w   [NU];
    logic [3:0] nsi_w  [NU];
    logic [1:0] win_w  [NU];
    int         cnt_w  [NU][4];

    logic [3:0] vec_tab [6];
    logic [3:0] so_tab  [6];
    int n_cmp = 0;
    int n_bad = 0;

    bit         m_act  [NU];
    int         m_cyc  [NU];
    int         m_hs   [NU];
    int         m_last [NU];
    logic [3:0] m_vec  [NU];
    int         m_cnt  [NU][4];
    int         m_win  [NU];
    bit         m_wv   [NU];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NU; g++) begin : g_dut
        localparam int CW = CW_T[g];
        logic [4*CW-1:0] cnt_flat;

        snn_timestep_scheduler #(
            .NUM_INPUTS  (4),
            .NUM_NEURONS (4),
            .NUM_STEPS   (NS_T[g]),
            .CNT_WIDTH   (CW),
            .CLEAR_CYCLES(CLR)
        ) u_dut (
            .clk             (clk),
            .rst             (rst),
            .start           (start_s[g]),
            .busy            (busy_w[g]),
            .done            (done_w[g]),
            .in_valid        (in_vld_s[g]),
            .in_ready        (rdy_w[g]),
            .in_spikes       (in_spk[g]),
            .neuron_rst      (nrst_w[g]),
            .neuron_spike_in (nsi_w[g]),
            .neuron_spike_out(so_s[g]),
            .spike_count     (cnt_flat),
            .winner          (win_w[g]),
            .winner_valid    (wv_w[g])
        );

        for (genvar i = 0; i < 4; i++) begin : g_unpack
            assign cnt_w[g][i] = 32'(cnt_flat[i*CW +: CW]);
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // Timeline model: cycles counted from the start cycle (0); a handshake at cycle h puts the
    // pulse on h+1, samples on h+2 and reopens ACCEPT at h+3.
    always @(negedge clk) begin
        for (int g = 0; g < NU; g++) begin
            bit         fin;
            bit         e_rdy;
            int         best;
            logic [3:0] e_nsi;
            if (!rst) begin
                m_act[g] = 1'b0;
                m_win[g] = 0;
                m_wv[g]  = 1'b0;
                for (int i = 0; i < 4; i++) m_cnt[g][i] = 0;
            end
            fin = m_act[g] && (m_hs[g] == NS_T[g]) && (m_cyc[g] == m_last[g] + 3 + SCAN);
            if (fin && WEN) begin
                best     = 0;
                m_win[g] = 0;
                for (int i = 0; i < 4; i++) begin
                    if (m_cnt[g][i] > best) begin
                        best     = m_cnt[g][i];
                        m_win[g] = i;
                    end
                end
                m_wv[g] = (best > 0);
            end
            e_rdy = m_act[g] && (m_hs[g] < NS_T[g]) && (m_cyc[g] >= m_last[g] + 3);
            e_nsi = (m_act[g] && (m_hs[g] > 0) && (m_cyc[g] == m_last[g] + 1)) ? m_vec[g] : 4'd0;

            chk($sformatf("u%0d busy", g), int'(busy_w[g]), int'(m_act[g]));
            chk($sformatf("u%0d in_ready", g), int'(rdy_w[g]), int'(e_rdy));
            chk($sformatf("u%0d neuron_rst", g), int'(nrst_w[g]), int'(m_act[g] && (m_cyc[g] <= CLR)));
            chk($sformatf("u%0d neuron_spike_in", g), int'(nsi_w[g]), int'(e_nsi));
            chk($sformatf("u%0d done", g), int'(done_w[g]), int'(fin));
            chk($sformatf("u%0d winner", g), int'(win_w[g]), m_win[g]);
            chk($sformatf("u%0d winner_valid", g), int'(wv_w[g]), int'(m_wv[g]));
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("u%0d count%0d", g, i), cnt_w[g][i], m_cnt[g][i]);
            end

            if (m_act[g]) begin
                if ((m_hs[g] > 0) && (m_cyc[g] == m_last[g] + 2)) begin
                    for (int i = 0; i < 4; i++) begin
                        if (so_s[g][i] && (m_cnt[g][i] < (1 << CW_T[g]) - 1)) m_cnt[g][i]++;
                    end
                end
                if (e_rdy && in_vld_s[g]) begin
                    m_hs[g]++;
                    m_last[g] = m_cyc[g];
                    m_vec[g]  = in_spk[g];
                end
                if (fin) m_act[g] = 1'b0;
                else     m_cyc[g]++;
            end else if (rst && start_s[g]) begin
                m_act[g]  = 1'b1;
                m_cyc[g]  = 1;
                m_hs[g]   = 0;
                m_last[g] = CLR - 2;
                m_wv[g]   = 1'b0;
                for (int i = 0; i < 4; i++) m_cnt[g][i] = 0;
            end
        end
    end

    // One presentation on unit g; lat counts cycles from the start cycle to the done cycle inclusive.
    task automatic present(input int g, input int stall, input int abort_at, input bit poke,
                           output int lat, output int nsi_n, output int rdy_n);
        int k;
        int left;
        bit poked;
        k = 0; left = stall; poked = 1'b0; lat = 0; nsi_n = 0; rdy_n = 0;
        @(posedge clk); #1;
        start_s[g] = 1'b1;
        lat = 1;
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk); #1;
            start_s[g] = 1'b0;
            lat++;
            if (nsi_w[g] != 4'd0) nsi_n++;
            if (rdy_w[g]) rdy_n++;
            if (done_w[g]) return;
            if (poke && !poked && (k == 1) && rdy_w[g]) begin
                start_s[g] = 1'b1;
                poked      = 1'b1;
            end
            if ((k < NS_T[g]) && (left == 0)) begin
                in_vld_s[g] = 1'b1;
                in_spk[g]   = vec_tab[k];
            end else begin
                in_vld_s[g] = 1'b0;
            end
            if (in_vld_s[g] && rdy_w[g]) begin
                so_s[g] = so_tab[k];
                k++;
                left = stall;
                if (k == abort_at) begin
                    rst         = 1'b0;
                    in_vld_s[g] = 1'b0;
                    lat         = -1;
                    return;
                end
            end else if (rdy_w[g] && (left > 0)) begin
                left--;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL u%0d presentation timeout: got no done, expected done within 3000 cycles", g);
        lat = -1;
    endtask

    initial begin
        int lat, nn, rn;
        for (int g = 0; g < NU; g++) begin
            start_s[g] = 1'b0; in_vld_s[g] = 1'b0; in_spk[g] = 4'd0; so_s[g] = 4'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", int'(busy_w[0]), 0);
        chk("reset in_ready", int'(rdy_w[0]), 0);
        chk("reset neuron_rst", int'(nrst_w[0]), 0);
        chk("reset done", int'(done_w[0]), 0);
        chk("reset count0", cnt_w[0][0], 0);
        rst = 1'b1;

        // Basic run: neuron 2 fires every step.
        for (int k = 0; k < 6; k++) begin vec_tab[k] = 4'b1111; so_tab[k] = 4'b0100; end
        present(0, 0, 0, 1'b0, lat, nn, rn);
        chk("basic latency", lat, WEN ? 20 : 16);
        chk("basic count2", cnt_w[0][2], 4);
        chk("basic count0", cnt_w[0][0], 0);
        chk("basic count3", cnt_w[0][3], 0);
        chk("basic pulse cycles", nn, 4);
        chk("basic ready cycles", rn, 4);
        chk("basic winner", int'(win_w[0]), WEN ? 2 : 0);
        chk("basic winner_valid", int'(wv_w[0]), WEN ? 1 : 0);

        // Backpressure: 5 idle cycles of in_valid before each vector.
        present(0, 5, 0, 1'b0, lat, nn, rn);
        chk("stall latency", lat, WEN ? 40 : 36);
        chk("stall pulse cycles", nn, 4);
        chk("stall ready cycles", rn, 24);
        chk("stall count2", cnt_w[0][2], 4);
        chk("stall count1", cnt_w[0][1], 0);

        // Saturation: 2-bit counters, 6 steps, every neuron firing.
        for (int k = 0; k < 6; k++) begin vec_tab[k] = 4'b1010; so_tab[k] = 4'b1111; end
        present(1, 0, 0, 1'b0, lat, nn, rn);
        chk("sat latency", lat, WEN ? 26 : 22);
        for (int i = 0; i < 4; i++) chk($sformatf("sat count%0d", i), cnt_w[1][i], 3);

        // Tie {2,5,5,1} with several all-zero input vectors.
        vec_tab = '{4'b0001, 4'b0000, 4'b1000, 4'b0000, 4'b0110, 4'b0000};
        so_tab  = '{4'b0011, 4'b0111, 4'b0110, 4'b0110, 4'b0110, 4'b1100};
        present(2, 0, 0, 1'b0, lat, nn, rn);
        chk("tie count0", cnt_w[2][0], 2);
        chk("tie count1", cnt_w[2][1], 5);
        chk("tie count2", cnt_w[2][2], 5);
        chk("tie count3", cnt_w[2][3], 1);
        chk("tie winner", int'(win_w[2]), WEN ? 1 : 0);
        chk("tie winner_valid", int'(wv_w[2]), WEN ? 1 : 0);

        // Empty: no neuron ever fires.
        for (int k = 0; k < 6; k++) begin vec_tab[k] = 4'b1111; so_tab[k] = 4'b0000; end
        present(0, 0, 0, 1'b0, lat, nn, rn);
        chk("empty count2", cnt_w[0][2], 0);
        chk("empty winner", int'(win_w[0]), 0);
        chk("empty winner_valid", int'(wv_w[0]), 0);

        // Reset during step 2, then a clean presentation.
        for (int k = 0; k < 6; k++) so_tab[k] = 4'b0001;
        present(0, 0, 2, 1'b0, lat, nn, rn);
        #1;
        chk("abort busy", int'(busy_w[0]), 0);
        chk("abort in_ready", int'(rdy_w[0]), 0);
        chk("abort spike_in", int'(nsi_w[0]), 0);
        chk("abort count0", cnt_w[0][0], 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        present(0, 0, 0, 1'b0, lat, nn, rn);
        chk("after-reset latency", lat, WEN ? 20 : 16);
        chk("after-reset count0", cnt_w[0][0], 4);

        // start pulsed while in ACCEPT must not restart or clear.
        present(0, 0, 0, 1'b1, lat, nn, rn);
        chk("poke latency", lat, WEN ? 20 : 16);
        chk("poke count0", cnt_w[0][0], 4);
        chk("poke winner", int'(win_w[0]), 0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
